// File: rtl/read_arbiter_2m.sv
// read_arbiter_2m
//
// Connects two read masters to one read slave. The masters' AR requests are
// round-robin arbitrated, and the winner is copied into a one-entry register
// stage that drives the slave. On the way through, each ARID gets a
// master-select bit prepended, so the slave sees four tag streams. The R
// channel uses that top tag bit to route beats back to the owning master,
// with no added cycles.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID and READY are both high. Once S_ARVALID is high, it and all
// S_AR* fields stay unchanged until that edge. Master ARREADY is
// combinational and is high only for the current arbitration winner.
//
// Ports
//   ACLK, ARESET              clock, synchronous active-high reset
//   M0_AR*, M1_AR*            master read-address channels
//   S_AR*                     registered slave read-address channel
//   S_R*                      slave read-data channel
//   M0_R*, M1_R*              master read-data channels (RVALID gated by tag)
//   resp_err                  sticky: RLAST taken for a master with none outstanding
//   dbg_state                 AR FSM state (0 = IDLE, 1 = SEND)
//   dbg_cnt0, dbg_cnt1        outstanding-burst counters per master
module read_arbiter_2m #(
    parameter int BusWidth       = 32,
    parameter int IdBits         = 1,
    parameter int MaxOutstanding = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic [IdBits-1:0]   M0_ARID,
    input  logic [BusWidth-1:0] M0_ARADDR,
    input  logic [3:0]          M0_ARLEN,
    input  logic [1:0]          M0_ARSIZE,
    input  logic [1:0]          M0_ARBURST,
    input  logic                M0_ARVALID,
    output logic                M0_ARREADY,

    input  logic [IdBits-1:0]   M1_ARID,
    input  logic [BusWidth-1:0] M1_ARADDR,
    input  logic [3:0]          M1_ARLEN,
    input  logic [1:0]          M1_ARSIZE,
    input  logic [1:0]          M1_ARBURST,
    input  logic                M1_ARVALID,
    output logic                M1_ARREADY,

    output logic [IdBits:0]     S_ARID,
    output logic [BusWidth-1:0] S_ARADDR,
    output logic [3:0]          S_ARLEN,
    output logic [1:0]          S_ARSIZE,
    output logic [1:0]          S_ARBURST,
    output logic [1:0]          S_ARLOCK,
    output logic [3:0]          S_ARCACHE,
    output logic [2:0]          S_ARPROT,
    output logic                S_ARVALID,
    input  logic                S_ARREADY,

    input  logic [IdBits:0]     S_RID,
    input  logic [BusWidth-1:0] S_RDATA,
    input  logic [1:0]          S_RRESP,
    input  logic                S_RLAST,
    input  logic                S_RVALID,
    output logic                S_RREADY,

    output logic [IdBits-1:0]   M0_RID,
    output logic [BusWidth-1:0] M0_RDATA,
    output logic [1:0]          M0_RRESP,
    output logic                M0_RLAST,
    output logic                M0_RVALID,
    input  logic                M0_RREADY,

    output logic [IdBits-1:0]   M1_RID,
    output logic [BusWidth-1:0] M1_RDATA,
    output logic [1:0]          M1_RRESP,
    output logic                M1_RLAST,
    output logic                M1_RVALID,
    input  logic                M1_RREADY,

    output logic                resp_err,
    output logic                dbg_state,
    output logic [2:0]          dbg_cnt0,
    output logic [2:0]          dbg_cnt1
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);

    state_t              state;
    logic                rr_ptr;
    logic                owner;
    logic [2:0]          cnt0;
    logic [2:0]          cnt1;

    logic [IdBits:0]     ar_id_q;
    logic [BusWidth-1:0] ar_addr_q;
    logic [3:0]          ar_len_q;
    logic [1:0]          ar_size_q;
    logic [1:0]          ar_burst_q;

    logic elig0, elig1;
    logic grant0, grant1;
    logic ar_done;
    logic r_sel;
    logic r_last_hs;
    logic inc0, inc1, dec0, dec1;

    // A master may compete only while it is below its outstanding limit.
    assign elig0 = M0_ARVALID && (cnt0 < MaxCnt);
    assign elig1 = M1_ARVALID && (cnt1 < MaxCnt);

    // rr_ptr names the master that has priority in the next IDLE cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (rr_ptr == 1'b0) begin
                if (elig0)      grant0 = 1'b1;
                else if (elig1) grant1 = 1'b1;
            end else begin
                if (elig1)      grant1 = 1'b1;
                else if (elig0) grant0 = 1'b1;
            end
        end
    end

    assign M0_ARREADY = grant0;
    assign M1_ARREADY = grant1;

    assign S_ARVALID = (state == SEND);
    assign S_ARID    = ar_id_q;
    assign S_ARADDR  = ar_addr_q;
    assign S_ARLEN   = ar_len_q;
    assign S_ARSIZE  = ar_size_q;
    assign S_ARBURST = ar_burst_q;
    assign S_ARLOCK  = 2'b00;
    assign S_ARCACHE = 4'b0000;
    assign S_ARPROT  = 3'b000;

    // R path is purely combinational and does not depend on the AR state.
    assign r_sel     = S_RID[IdBits];
    assign M0_RVALID = S_RVALID && !r_sel;
    assign M1_RVALID = S_RVALID &&  r_sel;
    assign S_RREADY  = r_sel ? M1_RREADY : M0_RREADY;

    assign M0_RID   = S_RID[IdBits-1:0];
    assign M1_RID   = S_RID[IdBits-1:0];
    assign M0_RDATA = S_RDATA;
    assign M1_RDATA = S_RDATA;
    assign M0_RRESP = S_RRESP;
    assign M1_RRESP = S_RRESP;
    assign M0_RLAST = S_RLAST;
    assign M1_RLAST = S_RLAST;

    assign ar_done   = (state == SEND) && S_ARREADY;
    assign r_last_hs = S_RVALID && S_RREADY && S_RLAST;
    assign inc0      = ar_done && !owner;
    assign inc1      = ar_done &&  owner;
    assign dec0      = r_last_hs && !r_sel;
    assign dec1      = r_last_hs &&  r_sel;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            cnt0       <= 3'd0;
            cnt1       <= 3'd0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        ar_id_q    <= {grant1, grant1 ? M1_ARID : M0_ARID};
                        ar_addr_q  <= grant1 ? M1_ARADDR  : M0_ARADDR;
                        ar_len_q   <= grant1 ? M1_ARLEN   : M0_ARLEN;
                        ar_size_q  <= grant1 ? M1_ARSIZE  : M0_ARSIZE;
                        ar_burst_q <= grant1 ? M1_ARBURST : M0_ARBURST;
                        owner      <= grant1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (S_ARREADY) begin
                        rr_ptr <= ~owner;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Issue and retire in the same cycle cancel out. A retire with
            // nothing outstanding is a slave protocol error: hold at zero.
            if (inc0 && !dec0)                    cnt0 <= cnt0 + 3'd1;
            else if (dec0 && !inc0 && cnt0 != 0)  cnt0 <= cnt0 - 3'd1;
            if (inc1 && !dec1)                    cnt1 <= cnt1 + 3'd1;
            else if (dec1 && !inc1 && cnt1 != 0)  cnt1 <= cnt1 - 3'd1;

            if ((dec0 && cnt0 == 0) || (dec1 && cnt1 == 0))
                resp_err <= 1'b1;
        end
    end

    assign dbg_state = state;
    assign dbg_cnt0  = cnt0;
    assign dbg_cnt1  = cnt1;

endmodule

// File: tb/tb_read_arbiter_2m.sv
module tb_read_arbiter_2m;

    localparam int BW   = 32;
    localparam int IB   = 1;
    localparam int MAXO = 4;
    localparam int W    = 42;   // {tag, addr, len, size, burst}

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [IB-1:0] M0_ARID, M1_ARID;
    logic [BW-1:0] M0_ARADDR, M1_ARADDR;
    logic [3:0]    M0_ARLEN, M1_ARLEN;
    logic [1:0]    M0_ARSIZE, M1_ARSIZE, M0_ARBURST, M1_ARBURST;
    logic          M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
    logic [IB:0]   S_ARID;
    logic [BW-1:0] S_ARADDR;
    logic [3:0]    S_ARLEN;
    logic [1:0]    S_ARSIZE, S_ARBURST, S_ARLOCK;
    logic [3:0]    S_ARCACHE;
    logic [2:0]    S_ARPROT;
    logic          S_ARVALID, S_ARREADY;
    logic [IB:0]   S_RID;
    logic [BW-1:0] S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RLAST, S_RVALID, S_RREADY;
    logic [IB-1:0] M0_RID, M1_RID;
    logic [BW-1:0] M0_RDATA, M1_RDATA;
    logic [1:0]    M0_RRESP, M1_RRESP;
    logic          M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID, M0_RREADY, M1_RREADY;
    logic          resp_err, dbg_state;
    logic [2:0]    dbg_cnt0, dbg_cnt1;

    read_arbiter_2m #(.BusWidth(BW), .IdBits(IB), .MaxOutstanding(MAXO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN),
        .M0_ARSIZE(M0_ARSIZE), .M0_ARBURST(M0_ARBURST),
        .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN),
        .M1_ARSIZE(M1_ARSIZE), .M1_ARBURST(M1_ARBURST),
        .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
        .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARLOCK(S_ARLOCK),
        .S_ARCACHE(S_ARCACHE), .S_ARPROT(S_ARPROT),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
        .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
        .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .resp_err(resp_err), .dbg_state(dbg_state),
        .dbg_cnt0(dbg_cnt0), .dbg_cnt1(dbg_cnt1)
    );

    // clock
    always #5 ACLK = ~ACLK;

    // reference model: one pending slave request, per-master burst counts
    int             checks = 0;
    int             errors = 0;
    bit             m_busy = 1'b0;
    bit             m_owner = 1'b0;
    bit             m_rr = 1'b0;
    int             m_cnt[2] = '{0, 0};
    bit             m_err = 1'b0;
    logic [W-1:0]   exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        bit elig[2];
        if (m_busy) return -1;
        elig[0] = M0_ARVALID && (m_cnt[0] < MAXO);
        elig[1] = M1_ARVALID && (m_cnt[1] < MAXO);
        if (elig[m_rr])  return int'(m_rr);
        if (elig[!m_rr]) return int'(!m_rr);
        return -1;
    endfunction

    // One clock: check every output against the model, clock, advance model.
    task automatic step();
        int  win;
        bit  sel;
        bit  dec[2];
        bit  inc[2];
        #1;
        win = model_winner();
        sel = S_RID[IB];
        chk("m0_arready", M0_ARREADY, win == 0);
        chk("m1_arready", M1_ARREADY, win == 1);
        chk("s_arvalid", S_ARVALID, m_busy);
        if (m_busy && exp_q.size() > 0)
            chk("s_ar_fields", {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST}, exp_q[0]);
        chk("s_ar_const", {S_ARLOCK, S_ARCACHE, S_ARPROT}, 0);
        chk("m0_rvalid", M0_RVALID, S_RVALID && !sel);
        chk("m1_rvalid", M1_RVALID, S_RVALID && sel);
        chk("s_rready", S_RREADY, sel ? M1_RREADY : M0_RREADY);
        chk("r_fields", {M0_RID, M1_RID, M0_RDATA, M1_RRESP, M0_RLAST},
            {S_RID[0], S_RID[0], S_RDATA, S_RRESP, S_RLAST});
        chk("m1_rdata", M1_RDATA, S_RDATA);
        chk("resp_err", resp_err, m_err);
        chk("cnt0", dbg_cnt0, m_cnt[0]);
        chk("cnt1", dbg_cnt1, m_cnt[1]);
        @(posedge ACLK);
        if (ARESET) begin
            m_busy = 0; m_owner = 0; m_rr = 0; m_err = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
            exp_q.delete();
        end else begin
            inc[0] = 0; inc[1] = 0;
            if (win == 0) begin
                exp_q.push_back({1'b0, M0_ARID, M0_ARADDR, M0_ARLEN, M0_ARSIZE, M0_ARBURST});
                m_busy = 1; m_owner = 0;
            end else if (win == 1) begin
                exp_q.push_back({1'b1, M1_ARID, M1_ARADDR, M1_ARLEN, M1_ARSIZE, M1_ARBURST});
                m_busy = 1; m_owner = 1;
            end else if (m_busy && S_ARREADY) begin
                void'(exp_q.pop_front());
                inc[m_owner] = 1;
                m_rr = !m_owner;
                m_busy = 0;
            end
            dec[0] = S_RVALID && S_RLAST && !sel && M0_RREADY;
            dec[1] = S_RVALID && S_RLAST &&  sel && M1_RREADY;
            for (int m = 0; m < 2; m++) begin
                if (dec[m] && m_cnt[m] == 0) m_err = 1;
                if (inc[m] && !dec[m])                    m_cnt[m]++;
                else if (dec[m] && !inc[m] && m_cnt[m] > 0) m_cnt[m]--;
            end
        end
        #1;
    endtask

    // driver tasks
    task automatic clear_inputs();
        M0_ARID = 0; M0_ARADDR = 0; M0_ARLEN = 0; M0_ARSIZE = 0; M0_ARBURST = 0; M0_ARVALID = 0;
        M1_ARID = 0; M1_ARADDR = 0; M1_ARLEN = 0; M1_ARSIZE = 0; M1_ARBURST = 0; M1_ARVALID = 0;
        S_ARREADY = 0; S_RID = 0; S_RDATA = 0; S_RRESP = 0; S_RLAST = 0; S_RVALID = 0;
        M0_RREADY = 0; M1_RREADY = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESET = 1;
        step();
        ARESET = 0;
    endtask

    initial begin
        clear_inputs();
        ARESET = 1;
        @(posedge ACLK);
        #1;
        do_reset();

        // reset values
        #1;
        chk("rst_s_arvalid", S_ARVALID, 0);
        chk("rst_s_araddr", S_ARADDR, 0);
        chk("rst_arready", {M0_ARREADY, M1_ARREADY}, 0);
        chk("rst_rvalid", {M0_RVALID, M1_RVALID, S_RREADY}, 0);
        chk("rst_state", dbg_state, 0);

        // single M0 request
        M0_ARVALID = 1; M0_ARID = 1; M0_ARADDR = 32'h100; M0_ARLEN = 3; S_ARREADY = 1;
        #1;
        chk("t1_m0_arready", M0_ARREADY, 1);
        step();
        M0_ARVALID = 0;
        #1;
        chk("t1_s_arvalid", S_ARVALID, 1);
        chk("t1_s_arid", S_ARID, 2'b01);
        chk("t1_s_araddr", S_ARADDR, 32'h100);
        chk("t1_s_arlen", S_ARLEN, 3);
        step();
        #1;
        chk("t1_cnt0", dbg_cnt0, 1);
        chk("t1_idle", dbg_state, 0);

        // alternating grants with both masters requesting
        do_reset();
        M0_ARVALID = 1; M1_ARVALID = 1; M0_ARADDR = 32'hA0; M1_ARADDR = 32'hB0; S_ARREADY = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_alt_tag", S_ARID[1], k % 2);
            step();
        end
        M0_ARVALID = 0; M1_ARVALID = 0;

        // outstanding limit for M1
        do_reset();
        M1_ARVALID = 1; M1_ARADDR = 32'h200; S_ARREADY = 1;
        repeat (2 * MAXO) step();
        #1;
        chk("t3_cnt1_full", dbg_cnt1, MAXO);
        M0_ARVALID = 1; M0_ARADDR = 32'h300;
        #1;
        chk("t3_m1_blocked", M1_ARREADY, 0);
        chk("t3_m0_granted", M0_ARREADY, 1);
        step();
        step();
        M0_ARVALID = 0;
        #1;
        chk("t3_m1_still_blocked", M1_ARREADY, 0);
        S_RVALID = 1; S_RID = 2'b10; S_RLAST = 1; M1_RREADY = 1;
        step();
        S_RVALID = 0; S_RLAST = 0; M1_RREADY = 0;
        #1;
        chk("t3_cnt1_after_rlast", dbg_cnt1, MAXO - 1);
        chk("t3_m1_granted", M1_ARREADY, 1);
        step();
        M1_ARVALID = 0;
        S_ARREADY = 1;
        step();

        // slave stall in SEND
        do_reset();
        M0_ARVALID = 1; M0_ARADDR = 32'hABC; M0_ARLEN = 7; S_ARREADY = 0;
        step();
        M0_ARVALID = 1; M0_ARADDR = 32'h555; M1_ARVALID = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_valid", S_ARVALID, 1);
            chk("t4_stall_addr", S_ARADDR, 32'hABC);
            chk("t4_stall_ready", {M0_ARREADY, M1_ARREADY}, 0);
            step();
        end
        S_ARREADY = 1;
        step();
        #1;
        chk("t4_back_idle", dbg_state, 0);
        S_ARREADY = 0;
        step();
        // reset while in SEND drops the request and clears counters
        ARESET = 1; M0_ARVALID = 0; M1_ARVALID = 0;
        step();
        ARESET = 0;
        #1;
        chk("t4_rst_send_valid", S_ARVALID, 0);
        chk("t4_rst_cnt", {dbg_cnt0, dbg_cnt1}, 0);

        // R routing to M1
        S_RVALID = 1; S_RID = 2'b11; S_RDATA = 32'hDEADBEEF; M1_RREADY = 0; M0_RREADY = 1;
        #1;
        chk("t5_m1_rvalid", M1_RVALID, 1);
        chk("t5_m0_rvalid", M0_RVALID, 0);
        chk("t5_s_rready_lo", S_RREADY, 0);
        chk("t5_m1_rid", M1_RID, 1);
        step();
        M1_RREADY = 1;
        #1;
        chk("t5_s_rready_hi", S_RREADY, 1);
        step();
        clear_inputs();

        // RLAST with nothing outstanding
        do_reset();
        S_RVALID = 1; S_RID = 2'b00; S_RLAST = 1; M0_RREADY = 1;
        step();
        clear_inputs();
        #1;
        chk("t6_resp_err", resp_err, 1);
        chk("t6_cnt0_zero", dbg_cnt0, 0);
        repeat (3) step();
        chk("t6_resp_err_sticky", resp_err, 1);
        do_reset();
        #1;
        chk("t6_resp_err_cleared", resp_err, 0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            M0_ARVALID = 1'($urandom_range(0, 1));
            M1_ARVALID = 1'($urandom_range(0, 1));
            M0_ARID = 1'($urandom_range(0, 1));  M1_ARID = 1'($urandom_range(0, 1));
            M0_ARADDR = $urandom;                M1_ARADDR = $urandom;
            M0_ARLEN = 4'($urandom_range(0, 15)); M1_ARLEN = 4'($urandom_range(0, 15));
            M0_ARSIZE = 2'($urandom_range(0, 3)); M1_ARSIZE = 2'($urandom_range(0, 3));
            M0_ARBURST = 2'($urandom_range(0, 3)); M1_ARBURST = 2'($urandom_range(0, 3));
            S_ARREADY = ($urandom_range(0, 3) != 0);
            S_RVALID = 1'($urandom_range(0, 1));
            S_RID = 2'($urandom_range(0, 3));
            S_RDATA = $urandom;
            S_RRESP = 2'($urandom_range(0, 3));
            M0_RREADY = 1'($urandom_range(0, 1));
            M1_RREADY = 1'($urandom_range(0, 1));
            S_RLAST = (m_cnt[S_RID[1]] > 0) && ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_arbiter_2m.md
# read_arbiter_2m

Two-master read-channel arbiter and router placed in front of a single read slave that tracks four tag streams (2 masters × 2 IDs). It round-robin arbitrates the masters' AR channels, extends each ARID with a master-select bit to form the slave's 2-bit tag, and limits outstanding bursts per master. On the return path it steers R beats back to the owning master by the tag's top bit.

## Interface
Parameters:
- BusWidth, 32, address/data width
- IdBits, 1, master-side ID width; slave-side tag width is IdBits+1
- MaxOutstanding, 4, max bursts in flight per master (1..7)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset: one clock; reset is synchronous and active-high
- M0_ARID / M1_ARID  in  IdBits  master read ID
- M0_ARADDR / M1_ARADDR  in  BusWidth  burst start address
- M0_ARLEN / M1_ARLEN  in  4  beats minus one
- M0_ARSIZE / M1_ARSIZE  in  2  bytes per beat code
- M0_ARBURST / M1_ARBURST  in  2  burst type
- M0_ARVALID / M1_ARVALID  in  1  AR request
- M0_ARREADY / M1_ARREADY  out  1  AR accept
- S_ARID  out  IdBits+1  tag = {master, ARID}
- S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST  out  BusWidth/4/2/2  registered copy of granted request
- S_ARLOCK, S_ARCACHE, S_ARPROT  out  2/4/3  constant 0
- S_ARVALID  out  1;  S_ARREADY  in  1
- S_RID  in  IdBits+1;  S_RDATA  in  BusWidth;  S_RRESP  in  2;  S_RLAST  in  1;  S_RVALID  in  1
- S_RREADY  out  1  routed RREADY of owning master
- M0_RID / M1_RID  out  IdBits  S_RID[IdBits-1:0]
- M0_RDATA / M1_RDATA, M0_RRESP / M1_RRESP, M0_RLAST / M1_RLAST  out  pass-through of slave R fields (both masters)
- M0_RVALID / M1_RVALID  out  1  S_RVALID gated by owner
- M0_RREADY / M1_RREADY  in  1
- resp_err  out  1  sticky: RLAST accepted for a master with zero outstanding

## Operation
- AR FSM, two states: IDLE, SEND.
- IDLE: eligible(m) = Mm_ARVALID && cnt[m] < MaxOutstanding. Winner = rr_ptr if eligible, else the other if eligible, else none. Mm_ARREADY = 1 (combinational) only for the winner. On that edge: capture fields into S_AR registers, S_ARID = {m, Mm_ARID}, owner = m, go SEND.
- SEND: S_ARVALID = 1, fields stable; both Mm_ARREADY = 0. On S_ARVALID && S_ARREADY: cnt[owner] += 1, rr_ptr = ~owner, go IDLE.
- R routing: sel = S_RID[IdBits]. Msel_RVALID = S_RVALID; other master RVALID = 0. S_RREADY = Msel_RREADY. Data/resp/last broadcast to both masters (only RVALID qualifies).
- On S_RVALID && S_RREADY && S_RLAST: cnt[sel] -= 1; if cnt[sel] == 0, hold at 0 and set resp_err.
- Same-cycle increment and decrement of one master's counter: net unchanged. Different masters: both applied.
- cnt width = 3 bits; never exceeds MaxOutstanding, never underflows.
- R path independent of AR FSM state; beats flow while SEND is stalled.

## Timing
- Reset (ARESET high at a rising edge): state IDLE, rr_ptr = 0, cnt[0..1] = 0, owner = 0, S_AR* registers = 0, S_ARVALID = 0, resp_err = 0. Combinational outputs with all inputs 0: Mm_ARREADY = 0, Mm_RVALID = 0, S_RREADY = 0.
- Reset in SEND: request dropped, S_ARVALID low the cycle after reset edge; counters cleared regardless of bursts in flight.
- AR latency: master handshake at edge N, S_ARVALID high from cycle N+1; earliest next master accept at edge N+2 (slave accepting at N+1). Sustained throughput: one AR per 2 cycles.
- S_ARVALID never drops before S_ARREADY; S_AR fields never change while S_ARVALID is high.
- R path: zero-cycle combinational, no added latency, no buffering.

## Test plan
- Reset then M0 ARID=1, ARADDR=0x100, ARLEN=3, S_ARREADY=1 -> M0_ARREADY=1 in cycle 0; S_ARVALID=1, S_ARID=2'b01, S_ARADDR=0x100 in cycle 1; cnt[0]=1.
- Both masters request continuously with rr_ptr=0, S_ARREADY=1 -> grants alternate M0, M1, M0, M1; S_ARID top bit alternates 0,1,0,1.
- M1 issues 4 bursts with no R returned -> 5th M1 request not accepted, M0 still granted; one S_RLAST beat with S_RID=2'b10 accepted -> M1 granted next IDLE.
- S_ARREADY held 0 for 5 cycles in SEND -> S_ARVALID and fields stable, both Mm_ARREADY=0; accept on 6th -> return to IDLE.
- S_RVALID=1, S_RID=2'b11, M1_RREADY=0 then 1 -> M1_RVALID=1, M0_RVALID=0, S_RREADY follows M1_RREADY; M1_RID=1.
- S_RLAST accepted for M0 with cnt[0]=0 -> cnt stays 0, resp_err=1 until ARESET.
